// File: rtl/four_one_rr_mux_pkg.sv
// -----------------------------------------------------------------------------
// four_one_rr_mux_pkg
// Shared constants and types for the 4:1 round-robin gathering mux.
// The lane index constants use the same encoding as the 1:4 demux select
// (sel = i means lane i), so a downstream demux can restore lane routing
// from out_sel.
//
// Contents:
//   NUM_LANES, SEL_W       lane count and lane-tag width
//   LANE0..LANE3           lane index constants
//   CNT_W, CNT_MAX         per-lane grant counter width / saturation value
//   mux_state_e            output register state (EMPTY / FULL)
//   next_lane()            2-bit wrapping successor of a lane index
// -----------------------------------------------------------------------------
package four_one_rr_mux_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  localparam logic [SEL_W-1:0] LANE0 = 2'd0;
  localparam logic [SEL_W-1:0] LANE1 = 2'd1;
  localparam logic [SEL_W-1:0] LANE2 = 2'd2;
  localparam logic [SEL_W-1:0] LANE3 = 2'd3;

  localparam int         CNT_W   = 8;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  // The state encoding is exactly out_valid: EMPTY = 0, FULL = 1.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } mux_state_e;

  // Successor lane with natural 2-bit wrap (lane 3 -> lane 0).
  function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] lane);
    return lane + 2'd1;
  endfunction

endpackage

// File: rtl/four_one_rr_mux_if.sv
// -----------------------------------------------------------------------------
// four_one_rr_mux_if
// Handshake bundle between the four input lanes, the mux and the downstream
// consumer.
//
// Valid/ready rule for every channel in this bundle: a word moves on a rising
// clk edge exactly when valid and ready are both high in the cycle before it.
// The mux holds out_valid/out_data/out_sel stable until out_ready is seen.
// in_ready may depend combinationally on in_valid; the upstream side must not
// make in_valid depend on in_ready.
//
// Signals:
//   in_valid  [NUM_LANES]        per-lane valid, bit i = lane i
//   in_data   [NUM_LANES*WIDTH]  packed lane data, lane i at [i*WIDTH +: WIDTH]
//   in_ready  [NUM_LANES]        per-lane ready, at most one bit high
//   out_valid                    output register holds a word
//   out_data  [WIDTH]            registered word
//   out_sel   [SEL_W]            lane the word came from
//   out_ready                    downstream accepts the word
//
// Modports:
//   master  environment side (drives lanes and out_ready)
//   slave   mux side
// -----------------------------------------------------------------------------
interface four_one_rr_mux_if
  import four_one_rr_mux_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic [NUM_LANES-1:0]       in_valid;
  logic [NUM_LANES*WIDTH-1:0] in_data;
  logic [NUM_LANES-1:0]       in_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic [SEL_W-1:0]           out_sel;
  logic                       out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );

endinterface

// File: rtl/four_one_rr_mux_rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
// Purely combinational 4-way round-robin arbiter. Lanes are scanned in the
// order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first requesting lane wins.
//
// Ports:
//   req       [4]  request per lane
//   ptr       [2]  highest-priority lane for this cycle
//   en        [1]  when low, the one-hot grant is forced to zero
//   grant     [4]  one-hot grant (zero when en is low or no request)
//   grant_idx [2]  index of the winning lane (LANE0 when no request)
//   any_grant [1]  at least one lane is requesting (independent of en)
// -----------------------------------------------------------------------------
module rr_arbiter4
  import four_one_rr_mux_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  input  logic                 en,
  output logic [NUM_LANES-1:0] grant,
  output logic [SEL_W-1:0]     grant_idx,
  output logic                 any_grant
);

  logic [SEL_W-1:0] lane;

  always_comb begin
    grant_idx = LANE0;
    any_grant = 1'b0;
    lane      = LANE0;
    // Scan from the lowest-priority offset down to ptr itself so the last
    // hit, which is the one that sticks, is the highest-priority requester.
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      lane = ptr + SEL_W'(k);
      if (req[lane]) begin
        grant_idx = lane;
        any_grant = 1'b1;
      end
    end

    grant = '0;
    if (en && any_grant) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/four_one_rr_mux.sv
// -----------------------------------------------------------------------------
// four_one_rr_mux
// Sequential 4:1 round-robin multiplexer. Gathers words from four valid/ready
// input lanes and serialises them into one registered output channel tagged
// with the source lane (out_sel, same encoding as the 1:4 demux select).
//
// The output register loads whenever it is empty or being drained in the
// same cycle (load_en), giving one word per cycle at full throughput. The
// round-robin pointer moves to the lane after the one just served, so every
// continuously valid lane is served within four transfers.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bus          four_one_rr_mux_if.slave (lanes in, tagged word out)
//   dbg_state    output register state (ST_EMPTY / ST_FULL)
//   dbg_ptr      current round-robin pointer
//   grant_count  [4*8] saturating per-lane transfer counters, lane i at
//                [i*8 +: 8]; present only when RR_MUX_GRANT_COUNT_EN is defined
//
// Build option: RR_MUX_GRANT_COUNT_EN adds the grant_count port and counters.
// -----------------------------------------------------------------------------
module four_one_rr_mux
  import four_one_rr_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  four_one_rr_mux_if.slave           bus,
  output mux_state_e                 dbg_state,
  output logic [SEL_W-1:0]           dbg_ptr
`ifdef RR_MUX_GRANT_COUNT_EN
  ,
  output logic [NUM_LANES*CNT_W-1:0] grant_count
`endif
);

  mux_state_e           state_q;
  logic [WIDTH-1:0]     data_q;
  logic [SEL_W-1:0]     sel_q;
  logic [SEL_W-1:0]     ptr_q;

  logic                 load_en;
  logic                 arb_en;
  logic [NUM_LANES-1:0] grant;
  logic [SEL_W-1:0]     grant_idx;
  logic                 any_grant;
  logic                 xfer;
  logic [WIDTH-1:0]     lane_data;

  // Register can take a new word when empty or when its word leaves now.
  // out_ready while empty is therefore irrelevant.
  assign load_en = (state_q == ST_EMPTY) || bus.out_ready;

  // Ready is held low through reset so nothing is accepted and then lost.
  assign arb_en = load_en && !rst;

  rr_arbiter4 u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign bus.in_ready = grant;
  assign xfer         = |(bus.in_valid & grant);
  assign lane_data    = bus.in_data[grant_idx*WIDTH +: WIDTH];

  // Output register state machine. The state bit is out_valid itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= LANE0;
      ptr_q   <= LANE0;
    end else if (load_en) begin
      if (xfer) begin
        state_q <= ST_FULL;
        data_q  <= lane_data;
        sel_q   <= grant_idx;
        ptr_q   <= next_lane(grant_idx);
      end else begin
        // Drained (or still empty) with nobody valid: data, tag and pointer
        // keep their last values.
        state_q <= ST_EMPTY;
      end
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign dbg_state     = state_q;
  assign dbg_ptr       = ptr_q;

`ifdef RR_MUX_GRANT_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_LANES];

  // Counters stop at CNT_MAX instead of wrapping.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else if (xfer && grant[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_cnt_out
    assign grant_count[gi*CNT_W +: CNT_W] = cnt_q[gi];
  end
`endif

endmodule
